// File: rtl/aes_stream_feeder.sv
// AES-128 core wrapper: packs four 32-bit words into a block, sequences the core through
// reset/start/wait-done and streams the ciphertext back. Optional timeout: AES_FEEDER_TIMEOUT_EN.
module aes_stream_feeder #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load,
   input  logic [127:0]     key_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             core_rst,
   output logic             core_start,
   output logic [127:0]     core_key,
   output logic [127:0]     core_plaintext,
   input  logic             core_done,
   input  logic [127:0]     core_ciphertext,
   output logic [CNT_W-1:0] blocks_done,
   output logic             err
);

   typedef enum logic [2:0] {StFill, StCoreRst, StStart, StWaitDone, StDrain, StErr} state_e;

   state_e             state_q, state_d;
   logic [1:0]         word_cnt_q, word_cnt_d;
   logic [1:0]         out_idx_q, out_idx_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       pt_q, pt_d;
   logic [127:0]       ct_q, ct_d;
   logic [CNT_W-1:0]   blocks_q, blocks_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               core_rst_q, core_rst_d;
   logic               core_start_q, core_start_d;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

`ifdef AES_FEEDER_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      out_idx_d  = out_idx_q;
      key_d      = key_q;
      pt_d       = pt_q;
      ct_d       = ct_q;
      blocks_d   = blocks_q;
`ifdef AES_FEEDER_TIMEOUT_EN
      wait_d     = wait_q;
`endif
      unique case (state_q)
         StFill: begin
            if (key_load) key_d = key_in;
            if (in_valid) begin
               // ~cnt selects the 32-bit lane from the top: word 0 lands in [127:96]
               pt_d[{~word_cnt_q, 5'd0} +: 32] = in_data;
               word_cnt_d = word_cnt_q + 2'd1;
               if (word_cnt_q == 2'd3) state_d = StCoreRst;
            end
         end
         StCoreRst: state_d = StStart;
         StStart: begin
            state_d = StWaitDone;
`ifdef AES_FEEDER_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         StWaitDone: begin
            if (core_done) begin
               ct_d      = core_ciphertext;
               out_idx_d = 2'd0;
               state_d   = StDrain;
            end
`ifdef AES_FEEDER_TIMEOUT_EN
            else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) state_d = StErr;
            else wait_d = wait_q + WAIT_W'(1);
`endif
         end
         StDrain: begin
            if (out_ready) begin
               out_idx_d = out_idx_q + 2'd1;
               if (out_idx_q == 2'd3) begin
                  blocks_d = blocks_q + CNT_W'(1);
                  state_d  = StFill;
               end
            end
         end
`ifdef AES_FEEDER_TIMEOUT_EN
         StErr: state_d = StErr;
`endif
         default: state_d = StFill;
      endcase

      // Outputs are registered from the next state so they are Moore with no decode lag
      in_ready_d   = (state_d == StFill);
      out_valid_d  = (state_d == StDrain);
      core_rst_d   = (state_d == StCoreRst) || (state_d == StErr);
      core_start_d = (state_d == StStart);
`ifdef AES_FEEDER_TIMEOUT_EN
      err_d        = (state_d == StErr);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StFill;
         word_cnt_q   <= 2'd0;
         out_idx_q    <= 2'd0;
         key_q        <= '0;
         pt_q         <= '0;
         ct_q         <= '0;
         blocks_q     <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         core_rst_q   <= 1'b1;
         core_start_q <= 1'b0;
`ifdef AES_FEEDER_TIMEOUT_EN
         wait_q       <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         out_idx_q    <= out_idx_d;
         key_q        <= key_d;
         pt_q         <= pt_d;
         ct_q         <= ct_d;
         blocks_q     <= blocks_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         core_rst_q   <= core_rst_d;
         core_start_q <= core_start_d;
`ifdef AES_FEEDER_TIMEOUT_EN
         wait_q       <= wait_d;
         err_q        <= err_d;
`endif
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_data       = ct_q[{~out_idx_q, 5'd0} +: 32];
   assign core_rst       = core_rst_q;
   assign core_start     = core_start_q;
   assign core_key       = key_q;
   assign core_plaintext = pt_q;
   assign blocks_done    = blocks_q;
`ifdef AES_FEEDER_TIMEOUT_EN
   assign err            = err_q;
`else
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Bench for aes_stream_feeder: behavioural core stand-in, event-level reference model
// checked every cycle, plus literal FIPS-197 expectations.
module tb_aes_stream_feeder;
   localparam int unsigned TO    = 1024;
   localparam int unsigned CNT_W = 16;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] ALT_KEY  = 128'hdeadbeef_01234567_89abcdef_feedf00d;

   logic clk = 1'b0, rst, key_load, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] key_in, core_key, core_plaintext;
   logic [127:0] core_ciphertext = '0;
   logic [31:0] in_data, out_data;
   logic core_rst, core_start, err;
   logic core_done = 1'b0;
   logic [CNT_W-1:0] blocks_done;

   aes_stream_feeder #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .core_rst(core_rst), .core_start(core_start), .core_key(core_key),
      .core_plaintext(core_plaintext), .core_done(core_done),
      .core_ciphertext(core_ciphertext), .blocks_done(blocks_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Stand-in cipher: real FIPS vector for the known pair, otherwise a keyed scramble
   function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] p);
      if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
      return {p[63:0], p[127:64]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   // Behavioural AES core: done is sticky until core_rst, random latency after start
   bit core_hang = 0;
   int lat = 0;
   always @(posedge clk) begin
      if (core_rst) begin
         core_done <= 1'b0;
         lat       <= 0;
      end else if (core_start) begin
         lat <= int'($urandom_range(1, 6));
      end else if (lat > 0) begin
         lat <= lat - 1;
         if (lat == 1 && !core_hang) begin
            core_done       <= 1'b1;
            core_ciphertext <= fake_aes(core_key, core_plaintext);
         end
      end
   end

   // Reference model: phase 0 fill, 1 core reset, 2 start, 3 wait, 4 drain, 5 error
   int m_phase = 0, m_wcnt = 0, m_oidx = 0, m_blocks = 0, m_wait = 0, rst_pulses = 0;
   bit m_rst_flag = 1;
   logic [127:0] m_pt = '0, m_key = '0, m_ct;
   logic [31:0] exp_q[$], got_q[$];
   logic prev_vld = 0, prev_rdy = 0, prev_core_rst = 1;
   logic [31:0] prev_data = '0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("rst_in_ready", in_ready, 1'b1);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_core_rst", core_rst, 1'b1);
         chk("rst_blocks", blocks_done, 0);
         chk("rst_regs", {core_key, core_plaintext}, 0);
         m_phase = 0; m_wcnt = 0; m_oidx = 0; m_blocks = 0; m_pt = '0; m_key = '0;
         exp_q.delete();
         m_rst_flag = 1; prev_vld = 0; prev_core_rst = 1;
      end else begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_phase == 4);
         chk("core_rst", core_rst, m_phase == 1 || m_phase == 5 || m_rst_flag);
         chk("core_start", core_start, m_phase == 2);
         chk("err", err, m_phase == 5);
         chk("blocks_done", blocks_done, 16'(m_blocks));
         if (m_phase == 2) begin
            chk("core_key", core_key, m_key);
            chk("core_plaintext", core_plaintext, m_pt);
         end
         if (prev_vld && !prev_rdy && out_valid) chk("out_hold", out_data, prev_data);
         if (core_rst && !prev_core_rst) rst_pulses++;
         prev_core_rst = core_rst; prev_vld = out_valid; prev_rdy = out_ready;
         prev_data = out_data; m_rst_flag = 0;
         case (m_phase)
            0: begin
               if (key_load) m_key = key_in;
               if (in_valid) begin
                  m_pt[(3 - m_wcnt) * 32 +: 32] = in_data;
                  m_wcnt++;
                  if (m_wcnt == 4) begin
                     m_ct = fake_aes(m_key, m_pt);
                     for (int i = 0; i < 4; i++) exp_q.push_back(m_ct[(3 - i) * 32 +: 32]);
                     m_wcnt = 0; m_phase = 1;
                  end
               end
            end
            1: m_phase = 2;
            2: begin m_phase = 3; m_wait = 0; end
            3: begin
               if (core_done) m_phase = 4;
`ifdef AES_FEEDER_TIMEOUT_EN
               else begin
                  m_wait++;
                  if (m_wait == TO) m_phase = 5;
               end
`endif
            end
            4: begin
               if (exp_q.size() == 0) chk("exp_queue_empty", 1, 0);
               else chk("out_data", out_data, exp_q[0]);
               if (out_ready) begin
                  got_q.push_back(out_data);
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  m_oidx++;
                  if (m_oidx == 4) begin m_oidx = 0; m_blocks++; m_phase = 0; end
               end
            end
            default: ;
         endcase
      end
   end

   // out_ready driver: 0 always ready, 1 random, 2 five stalled cycles per word
   int rdy_mode = 0;
   initial begin
      int cnt = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         cnt = (cnt + 1) % 6;
         case (rdy_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = (cnt == 5);
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic load_key(input logic [127:0] k);
      key_in = k; key_load = 1'b1;
      @(posedge clk); #1;
      key_load = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] blk, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         bit acc = 0;
         int n = 0;
         repeat ($urandom_range(0, max_gap)) begin in_valid = 1'b0; @(posedge clk); #1; end
         in_valid = 1'b1; in_data = blk[(3 - i) * 32 +: 32];
         while (!acc && n < 3000) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
         end
         chk("accept_timeout", acc, 1'b1);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_blocks(input int n);
      int t = 0;
      while (m_blocks < n && t < 8000) begin @(posedge clk); t++; end
      #1;
      chk("drain_timeout", m_blocks >= n, 1'b1);
   endtask

   task automatic wait_phase(input int ph, input int oidx);
      int t = 0;
      do begin @(posedge clk); #1; t++; end
      while (!(m_phase == ph && m_oidx == oidx) && t < 3000);
      chk("phase_timeout", t < 3000, 1'b1);
   endtask

   initial begin
      int p0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; key_load = 1'b0; key_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // FIPS-197 vector
      load_key(FIPS_KEY);
      send_block(FIPS_PT, 0);
      wait_blocks(1);
      for (int i = 0; i < 4; i++) chk("t1_word", got_q[i], FIPS_CT[(3 - i) * 32 +: 32]);
      chk("t1_blocks", blocks_done, 1);

      // back-to-back, no reload
      got_q.delete(); p0 = rst_pulses;
      send_block(FIPS_PT, 0);
      send_block(FIPS_PT, 0);
      wait_blocks(3);
      for (int i = 0; i < 4; i++) begin
         chk("t2_same", got_q[i + 4], got_q[i]);
         chk("t2_word", got_q[i + 4], FIPS_CT[(3 - i) * 32 +: 32]);
      end
      chk("t2_rst_pulses", rst_pulses - p0, 2);
      chk("t2_blocks", blocks_done, 3);

      // backpressure
      got_q.delete(); rdy_mode = 2;
      send_block(FIPS_PT, 0);
      wait_blocks(4);
      for (int i = 0; i < 4; i++) chk("t3_word", got_q[i], FIPS_CT[(3 - i) * 32 +: 32]);
      rdy_mode = 0;

      // input gaps, key_load during WAIT_DONE ignored
      got_q.delete();
      send_block(FIPS_PT, 1);
      wait_phase(3, 0);
      load_key(ALT_KEY);
      wait_blocks(5);
      send_block(FIPS_PT, 1);
      wait_blocks(6);
      for (int i = 0; i < 8; i++) chk("t4_word", got_q[i], FIPS_CT[(3 - (i % 4)) * 32 +: 32]);

      // randomized traffic
      rdy_mode = 1;
      for (int b = 0; b < 20; b++) begin
         if ($urandom_range(0, 2) == 0) load_key({$urandom, $urandom, $urandom, $urandom});
         send_block({$urandom, $urandom, $urandom, $urandom}, 2);
      end
      wait_blocks(26);
      chk("rand_blocks", blocks_done, 26);
      rdy_mode = 0;

      // reset mid-drain after two words
      send_block({$urandom, $urandom, $urandom, $urandom}, 0);
      wait_phase(4, 2);
      rst = 1'b1; #1;
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_in_ready", in_ready, 1'b1);
      chk("t5_core_rst", core_rst, 1'b1);
      chk("t5_blocks", blocks_done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_q.delete();
      load_key(FIPS_KEY);
      send_block(FIPS_PT, 0);
      wait_blocks(1);
      chk("t5_after_word0", got_q[0], 32'h69c4e0d8);
      chk("t5_after_blocks", blocks_done, 1);

`ifdef AES_FEEDER_TIMEOUT_EN
      begin
         int cnt = 0;
         core_hang = 1;
         send_block(FIPS_PT, 0);
         wait_phase(3, 0);
         while (!err && cnt < TO + 10) begin @(posedge clk); #1; cnt++; end
         chk("t6_timeout_len", cnt, TO);
         repeat (5) @(posedge clk);
         #1 chk("t6_in_ready", in_ready, 1'b0);
         rst = 1'b1; core_hang = 0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         @(posedge clk); #1;
         chk("t6_err_cleared", err, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, limit reached");
      $fatal(1, "watchdog");
   end
endmodule
